// File: rtl/frame_sequencer.sv
// frame_sequencer -- APU frame counter ($4017).
//   Divides the CPU clock into quarter-frame and half-frame clock-enable
//   strobes, in 4-step (mode 0, with frame IRQ) or 5-step (mode 1) mode.
//   Optional feature macro: FRAME_IRQ_EN (frame IRQ flag; tied 0 when undefined).
// Ports:
//   clk          in   CPU clock, all state on rising edge
//   resetN       in   asynchronous active-low reset
//   writeEn      in   one-cycle strobe, CPU write to $4017
//   writeData    in   [7]=mode, [6]=irqInhibit, other bits ignored
//   statusRead   in   one-cycle strobe, CPU read of $4015 (clears frameIrq)
//   quarterFrame out  one-cycle pulse, envelope / linear counter enable
//   halfFrame    out  one-cycle pulse, length / sweep enable
//   frameIrq     out  frame interrupt flag (level)
module frame_sequencer #(
  parameter int CNT_W       = 16,
  parameter int Q1          = 7457,
  parameter int Q2          = 14913,
  parameter int Q3          = 22371,
  parameter int M0_END      = 29829,
  parameter int M1_END      = 37281,
  parameter int WRITE_DELAY = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       writeEn,
  input  logic [7:0] writeData,
  input  logic       statusRead,
  output logic       quarterFrame,
  output logic       halfFrame,
  output logic       frameIrq
);

  localparam int DLY_W = (WRITE_DELAY > 1) ? $clog2(WRITE_DELAY) : 1;

  localparam logic [CNT_W-1:0] Q1_C  = CNT_W'(Q1);
  localparam logic [CNT_W-1:0] Q2_C  = CNT_W'(Q2);
  localparam logic [CNT_W-1:0] Q3_C  = CNT_W'(Q3);
  localparam logic [CNT_W-1:0] M0_C  = CNT_W'(M0_END);
  localparam logic [CNT_W-1:0] M1_C  = CNT_W'(M1_END);
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(WRITE_DELAY - 1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             mode_q, mode_d;
  logic             pend_q, pend_d;
  logic             imm_q, imm_d;
  logic             qtr_q, qtr_d;
  logic             half_q, half_d;
  logic             restart, step_end, q_hit, h_hit;
  logic [CNT_W-1:0] end_c;

  always_comb begin
    mode_d  = mode_q;
    pend_d  = pend_q;
    dly_d   = dly_q;
    restart = 1'b0;
    // dly_q counts the edges left before the edge that loads count=0.
    // A write always re-arms the delay, even when one is already pending.
    if (writeEn) begin
      mode_d  = writeData[7];
      pend_d  = (WRITE_DELAY > 1);
      dly_d   = DLY_INIT;
      restart = (WRITE_DELAY == 1);
    end else if (pend_q && dly_q == DLY_ONE) begin
      pend_d  = 1'b0;
      restart = 1'b1;
    end else if (pend_q) begin
      dly_d   = dly_q - DLY_ONE;
    end

    // Wrap against the newly written mode so the count never sits beyond
    // the active END, including when a write shortens the frame.
    end_c   = mode_d ? M1_C : M0_C;
    if (restart || count_q >= end_c) count_d = '0;
    else                             count_d = count_q + CNT_W'(1);

    imm_d    = restart & mode_d;

    // Step decode belongs to the mode under which this count was reached.
    step_end = mode_q ? (count_q == M1_C) : (count_q == M0_C);
    q_hit    = (count_q == Q1_C) | (count_q == Q2_C) | (count_q == Q3_C) | step_end;
    h_hit    = (count_q == Q2_C) | step_end;

    // A restart drops a coincident step strobe; the mode-1 immediate strobe
    // is a single forced pulse that is never suppressed.
    qtr_d    = imm_q | (q_hit & ~restart);
    half_d   = imm_q | (h_hit & ~restart);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
      dly_q   <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      imm_q   <= 1'b0;
      qtr_q   <= 1'b0;
      half_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dly_q   <= dly_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      imm_q   <= imm_d;
      qtr_q   <= qtr_d;
      half_q  <= half_d;
    end
  end

  assign quarterFrame = qtr_q;
  assign halfFrame    = half_q;

`ifdef FRAME_IRQ_EN
  localparam logic [CNT_W-1:0] IRQ_A = CNT_W'(M0_END - 1);

  logic inh_q, inh_d, irq_q, irq_d, irq_set, irq_clr;
  logic unused_wdata;

  always_comb begin
    inh_d   = writeEn ? writeData[6] : inh_q;
    irq_set = ~mode_q & ~inh_q & ((count_q == IRQ_A) | (count_q == M0_C));
    irq_clr = statusRead | (writeEn & writeData[6]);
    // set has priority over any clear arriving in the same cycle
    irq_d   = irq_set | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inh_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      inh_q <= inh_d;
      irq_q <= irq_d;
    end
  end

  assign frameIrq     = irq_q;
  assign unused_wdata = ^writeData[5:0];
`else
  logic unused_in;
  assign frameIrq  = 1'b0;
  assign unused_in = ^{writeData[6:0], statusRead};
`endif

endmodule
